// File: rtl/veer_types.sv
// Shared types for the EXU ALU issue arbiter.
// Holds the issue-source encoding and the queue-depth ceiling.
package veer_types;

    typedef enum logic [1:0] {
        SRC_Q    = 2'd0,
        SRC_R0   = 2'd1,
        SRC_R1   = 2'd2,
        SRC_NONE = 2'd3
    } alu_src_e;

    localparam int ALU_ARB_DEPTH_MAX = 4;

endpackage

// File: rtl/exu_alu_issue_arb_if.sv
// Issue handshake bundle: two requesters (req0 older) and the ALU slot.
// master = requesters/ALU side, slave = the arbiter.
interface exu_alu_issue_arb_if #(
    parameter int PKT_W = 64
);
    import veer_types::*;

    logic             req0_valid;
    logic [PKT_W-1:0] req0_pkt;
    logic             req0_ready;
    logic             req1_valid;
    logic [PKT_W-1:0] req1_pkt;
    logic             req1_ready;
    logic             alu_valid;
    logic [PKT_W-1:0] alu_pkt;
    alu_src_e         alu_src;
    logic             alu_enable;

    modport master (
        output req0_valid, req0_pkt, req1_valid, req1_pkt,
        input  req0_ready, req1_ready,
        input  alu_valid, alu_pkt, alu_src, alu_enable
    );

    modport slave (
        input  req0_valid, req0_pkt, req1_valid, req1_pkt,
        output req0_ready, req1_ready,
        output alu_valid, alu_pkt, alu_src, alu_enable
    );

endinterface

// File: rtl/exu_alu_issue_fifo.sv
// In-order holding queue: DEPTH x PKT_W, two ordered write ports, one pop.
// Ports: clk, rst_l (sync, active-low), clear, wr0/wr1 en+data, pop, head, count.
module exu_alu_issue_fifo #(
    parameter int DEPTH = 2,
    parameter int PKT_W = 64,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             clear,
    input  logic             wr0_en,
    input  logic [PKT_W-1:0] wr0_data,
    input  logic             wr1_en,
    input  logic [PKT_W-1:0] wr1_data,
    input  logic             pop,
    output logic [PKT_W-1:0] head,
    output logic [CW-1:0]    count
);
    logic [PKT_W-1:0] mem_q [DEPTH];
    logic [PKT_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [AW-1:0]    w1_idx;

    // Power-of-two depth: pointers wrap by natural overflow.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        w1_idx   = wr0_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr0_en) mem_d[wr_ptr_q] = wr0_data;
            if (wr1_en) mem_d[w1_idx]   = wr1_data;
            wr_ptr_d = wr_ptr_q + AW'(wr0_en) + AW'(wr1_en);
            if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(wr0_en) + CW'(wr1_en) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/exu_alu_issue_arb.sv
// Age-ordered arbiter sharing one ALU issue slot between req0 (older) and req1.
// Ports: clk, rst_l, freeze, flush, io (slave), q_count, perf_conflict.
// Macro EXU_ALU_ISSUE_ARB_BYPASS_EN enables zero-latency issue from an empty queue.
module exu_alu_issue_arb
    import veer_types::*;
#(
    parameter int DEPTH = 2,
    parameter int PKT_W = 64,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic                 freeze,
    input  logic                 flush,
    exu_alu_issue_arb_if.slave   io,
    output logic [CW-1:0]        q_count,
    output logic [15:0]          perf_conflict
);
    logic [PKT_W-1:0] head;
    logic [CW-1:0]    count;
    logic             go, q_busy;
    logic             rdy0, rdy1, acc0, acc1;
    logic             wr0, wr1, pop;
    logic [PKT_W-1:0] wr0_data, wr1_data;
    alu_src_e         src;
    logic [15:0]      perf_q, perf_d;

    assign go     = rst_l & ~freeze & ~flush;
    assign q_busy = (count != '0);
    assign rdy0   = go & (count < CW'(DEPTH));
    assign rdy1   = go & ((count + CW'(io.req0_valid)) < CW'(DEPTH));
    assign acc0   = io.req0_valid & rdy0;
    assign acc1   = io.req1_valid & rdy1;

    always_comb begin
        src      = SRC_NONE;
        pop      = 1'b0;
        wr0      = 1'b0;
        wr1      = 1'b0;
        wr0_data = io.req0_pkt;
        wr1_data = io.req1_pkt;
`ifdef EXU_ALU_ISSUE_ARB_BYPASS_EN
        // Queue head is always older than anything arriving now.
        if (go & q_busy) begin
            src = SRC_Q;
            pop = 1'b1;
            wr0 = acc0;
            wr1 = acc1;
        end else if (acc0) begin
            src = SRC_R0;
            wr1 = acc1;
        end else if (acc1) begin
            src = SRC_R1;
        end
`else
        if (go & q_busy) begin
            src = SRC_Q;
            pop = 1'b1;
        end
        wr0 = acc0;
        wr1 = acc1;
`endif
    end

    exu_alu_issue_fifo #(
        .DEPTH (DEPTH),
        .PKT_W (PKT_W)
    ) u_fifo (
        .clk      (clk),
        .rst_l    (rst_l),
        .clear    (flush),
        .wr0_en   (wr0),
        .wr0_data (wr0_data),
        .wr1_en   (wr1),
        .wr1_data (wr1_data),
        .pop      (pop),
        .head     (head),
        .count    (count)
    );

    always_comb begin
        unique case (src)
            SRC_R0:  io.alu_pkt = io.req0_pkt;
            SRC_R1:  io.alu_pkt = io.req1_pkt;
            default: io.alu_pkt = head;
        endcase
    end

    assign io.req0_ready = rdy0;
    assign io.req1_ready = rdy1;
    assign io.alu_src    = src;
    assign io.alu_valid  = (src != SRC_NONE);
    assign io.alu_enable = (src != SRC_NONE);
    assign q_count       = count;

    // Counts cycles where the younger requester did not get the slot.
    always_comb begin
        perf_d = perf_q;
        if (io.req1_valid & ~freeze & ~flush &
            (src != SRC_R1) & (perf_q != 16'hFFFF))
            perf_d = perf_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_l) perf_q <= '0;
        else        perf_q <= perf_d;
    end

    assign perf_conflict = perf_q;

endmodule

// File: tb/tb_exu_alu_issue_arb.sv
// Self-checking bench for exu_alu_issue_arb (DEPTH=2, PKT_W=64).
// Directed vector table, random traffic vs a queue model, and a wrap sequence.
module tb_exu_alu_issue_arb;
    import veer_types::*;

    localparam int DEPTH = 2;
    localparam int PKT_W = 64;
`ifdef EXU_ALU_ISSUE_ARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_l, freeze, flush;
    logic [1:0]  q_count;
    logic [15:0] perf_conflict;

    exu_alu_issue_arb_if #(.PKT_W(PKT_W)) io ();

    exu_alu_issue_arb #(
        .DEPTH (DEPTH),
        .PKT_W (PKT_W)
    ) dut (
        .clk           (clk),
        .rst_l         (rst_l),
        .freeze        (freeze),
        .flush         (flush),
        .io            (io),
        .q_count       (q_count),
        .perf_conflict (perf_conflict)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          r, fz, fl, v0, v1;
        logic [63:0] p0, p1;
        bit          ev;
        alu_src_e    es;
        logic [63:0] ep;
        bit          er0, er1;
        int          ecnt, eperf;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit r, bit fz, bit fl,
                                bit v0, logic [63:0] p0,
                                bit v1, logic [63:0] p1,
                                bit ev, alu_src_e es, logic [63:0] ep,
                                bit er0, bit er1, int ecnt, int eperf);
        vec_t t;
        t.r = r; t.fz = fz; t.fl = fl;
        t.v0 = v0; t.p0 = p0; t.v1 = v1; t.p1 = p1;
        t.ev = ev; t.es = es; t.ep = ep;
        t.er0 = er0; t.er1 = er1; t.ecnt = ecnt; t.eperf = eperf;
        tbl.push_back(t);
    endfunction

    // Reference model: an ordered list of waiting packets.
    logic [63:0] mq[$];
    logic [63:0] issued[$];
    int          mperf;
    bit          acc0, acc1, m_ev;

    task automatic mstep();
        bit          ok, r0, r1, had;
        alu_src_e    es;
        logic [63:0] ep;
        #1;
        ok  = rst_l && !freeze && !flush;
        r0  = ok && (mq.size() < DEPTH);
        r1  = ok && ((mq.size() + int'(io.req0_valid)) < DEPTH);
        had = (mq.size() > 0);
        chk("q_count", 64'(q_count), 64'(mq.size()));
        chk("q_bound", 64'(q_count <= 2'(DEPTH)), 64'd1);
        chk("perf", 64'(perf_conflict), 64'(mperf));
        chk("req0_ready", 64'(io.req0_ready), 64'(r0));
        chk("req1_ready", 64'(io.req1_ready), 64'(r1));
        acc0 = r0 && io.req0_valid;
        acc1 = r1 && io.req1_valid;
        if (acc0) mq.push_back(io.req0_pkt);
        if (acc1) mq.push_back(io.req1_pkt);
        es = SRC_NONE;
        ep = '0;
        if (ok && mq.size() > 0 && (BYP || had)) begin
            ep = mq.pop_front();
            es = had ? SRC_Q : (acc0 ? SRC_R0 : SRC_R1);
        end
        m_ev = (es != SRC_NONE);
        chk("alu_valid", 64'(io.alu_valid), 64'(m_ev));
        chk("alu_enable", 64'(io.alu_enable), 64'(m_ev));
        chk("alu_src", 64'(io.alu_src), 64'(es));
        if (m_ev) begin
            chk("alu_pkt", io.alu_pkt, ep);
            issued.push_back(io.alu_pkt);
        end
        if (!rst_l) mperf = 0;
        else if (io.req1_valid && !freeze && !flush &&
                 es != SRC_R1 && mperf != 65535) mperf++;
        if (!rst_l || flush) mq.delete();
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_l = 1'b0; freeze = 1'b0; flush = 1'b0;
        io.req0_valid = 1'b0; io.req1_valid = 1'b0;
        @(negedge clk);
        mq.delete();
        issued.delete();
        mperf = 0;
        acc0  = 1'b0;
        acc1  = 1'b0;
    endtask

    localparam logic [63:0] A = 64'h1, B = 64'h2, C = 64'h3, D = 64'h4;
    localparam logic [63:0] E = 64'h5, F = 64'h6, G = 64'h7, H = 64'h8;

    initial begin
        int i0, i1, first_acc, first_iss;
        rst_l = 1'b0; freeze = 1'b0; flush = 1'b0;
        io.req0_valid = 1'b0; io.req0_pkt = '0;
        io.req1_valid = 1'b0; io.req1_pkt = '0;

        add(0,0,0, 1,A, 0,0, 0,SRC_NONE,0, 0,0,0,0);
        add(0,0,0, 1,A, 0,0, 0,SRC_NONE,0, 0,0,0,0);
`ifdef EXU_ALU_ISSUE_ARB_BYPASS_EN
        add(1,0,0, 1,A, 1,B, 1,SRC_R0,A,   1,1,0,0);
        add(1,0,0, 0,0, 0,0, 1,SRC_Q,B,    1,1,1,1);
        add(1,0,0, 0,0, 1,C, 1,SRC_R1,C,   1,1,0,1);
        add(1,0,0, 1,D, 1,E, 1,SRC_R0,D,   1,1,0,1);
        for (int k = 0; k < 3; k++)
            add(1,1,0, 1,F, 0,0, 0,SRC_NONE,0, 0,0,1,2);
        add(1,0,0, 1,F, 0,0, 1,SRC_Q,E,    1,0,1,2);
        add(1,0,1, 1,G, 1,H, 0,SRC_NONE,0, 0,0,1,2);
        add(1,0,0, 0,0, 0,0, 0,SRC_NONE,0, 1,1,0,2);
`else
        add(1,0,0, 1,A, 1,B, 0,SRC_NONE,0, 1,1,0,0);
        add(1,0,0, 1,C, 1,D, 1,SRC_Q,A,    0,0,2,1);
        add(1,0,0, 1,C, 1,D, 1,SRC_Q,B,    1,0,1,2);
        for (int k = 0; k < 3; k++)
            add(1,1,0, 1,E, 0,0, 0,SRC_NONE,0, 0,0,1,3);
        add(1,0,0, 0,0, 0,0, 1,SRC_Q,C,    1,1,1,3);
        add(1,0,0, 1,E, 1,F, 0,SRC_NONE,0, 1,1,0,3);
        add(1,1,1, 1,G, 1,H, 0,SRC_NONE,0, 0,0,2,4);
        add(1,0,0, 0,0, 0,0, 0,SRC_NONE,0, 1,1,0,4);
`endif

        foreach (tbl[i]) begin
            @(negedge clk);
            rst_l = tbl[i].r; freeze = tbl[i].fz; flush = tbl[i].fl;
            io.req0_valid = tbl[i].v0; io.req0_pkt = tbl[i].p0;
            io.req1_valid = tbl[i].v1; io.req1_pkt = tbl[i].p1;
            #1;
            chk($sformatf("v%0d_valid", i), 64'(io.alu_valid), 64'(tbl[i].ev));
            chk($sformatf("v%0d_src", i), 64'(io.alu_src), 64'(tbl[i].es));
            if (tbl[i].ev)
                chk($sformatf("v%0d_pkt", i), io.alu_pkt, tbl[i].ep);
            chk($sformatf("v%0d_rdy0", i), 64'(io.req0_ready), 64'(tbl[i].er0));
            chk($sformatf("v%0d_rdy1", i), 64'(io.req1_ready), 64'(tbl[i].er1));
            chk($sformatf("v%0d_cnt", i), 64'(q_count), 64'(tbl[i].ecnt));
            chk($sformatf("v%0d_perf", i), 64'(perf_conflict), 64'(tbl[i].eperf));
        end

        // Random traffic; requesters hold valid/pkt until accepted.
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!io.req0_valid || acc0) begin
                io.req0_valid = ($urandom_range(0, 99) < 60);
                io.req0_pkt   = {$urandom, $urandom};
            end
            if (!io.req1_valid || acc1) begin
                io.req1_valid = ($urandom_range(0, 99) < 60);
                io.req1_pkt   = {$urandom, $urandom};
            end
            freeze = ($urandom_range(0, 99) < 10);
            flush  = ($urandom_range(0, 99) < 4);
            rst_l  = ($urandom_range(0, 199) != 0);
            mstep();
        end

        // Nine back-to-back pairs: order must be A0,B0,A1,B1,...
        reset_dut();
        i0 = 0; i1 = 0; first_acc = -1; first_iss = -1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            rst_l = 1'b1; freeze = 1'b0; flush = 1'b0;
            io.req0_valid = (i0 < 9) && (i0 == i1);
            io.req0_pkt   = 64'hA000 + 64'(i0);
            io.req1_valid = (i1 < 9) && (i1 <= i0);
            io.req1_pkt   = 64'hB000 + 64'(i1);
            mstep();
            if ((acc0 || acc1) && first_acc < 0) first_acc = c;
            if (m_ev && first_iss < 0) first_iss = c;
            if (acc0) i0++;
            if (acc1) i1++;
            if (issued.size() == 18) break;
        end
        chk("wrap_issued", 64'(issued.size()), 64'd18);
        for (int k = 0; k < issued.size() && k < 18; k++)
            chk($sformatf("wrap_order%0d", k), issued[k],
                ((k % 2) == 0 ? 64'hA000 : 64'hB000) + 64'(k / 2));
        chk("first_latency", 64'(first_iss - first_acc), BYP ? 64'd0 : 64'd1);

        @(negedge clk);
        io.req0_valid = 1'b0;
        io.req1_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
